// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and line constants shared by the UART transmit and receive paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int UART_CLKS_PER_BIT = 16;
  localparam logic UART_LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter that flags the last sample_clk cycle of each bit
module uart_bit_timer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic sample_clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_end = cnt == LAST;
  always_ff @(posedge sample_clk)
    cnt <= (rst || clear || bit_end) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: valid/ready byte in, registered start/data/parity/stop serial frame out on RsTx
module uart_tx_serializer import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sample_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 RsTx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  uart_tx_state_t state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [IW-1:0] idx, idx_n;
  logic par, par_n, bit_end, done_n, line_n;
  // the timer is held cleared while idle so the start bit gets a full period from the accept edge
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .sample_clk(sample_clk),
    .rst(rst),
    .clear(state == IDLE),
    .bit_end(bit_end)
  );
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n = idx;
    par_n = par;
    done_n = 1'b0;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_n = START;
        shift_n = tx_data;
        par_n = ^tx_data ^ (PARITY_ODD != 0);
      end
      START: if (bit_end) begin
        state_n = DATA;
        idx_n = '0;
      end
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        idx_n = idx == LAST_DATA ? '0 : idx + IW'(1);
        if (idx == LAST_DATA) state_n = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: if (bit_end) begin
        idx_n = idx == LAST_STOP ? '0 : idx + IW'(1);
        state_n = idx == LAST_STOP ? IDLE : STOP;
        done_n = idx == LAST_STOP;
      end
      default: state_n = IDLE;
    endcase
    // line value is computed from the next state so RsTx can be a plain register
    line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] :
             state_n == PARITY ? par_n : UART_LINE_IDLE;
  end
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      RsTx <= UART_LINE_IDLE;
      tx_ready <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      RsTx <= line_n;
      tx_ready <= state_n == IDLE;
      tx_busy <= state_n != IDLE;
      tx_done <= done_n;
    end
  end
  always_ff @(posedge sample_clk) begin
    shift <= shift_n;
    par <= par_n;
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench over four configurations of the UART transmitter
module tb_uart_tx_serializer;
  logic sample_clk = 1'b0;
  logic rst = 1'b1;
  always #5 sample_clk = ~sample_clk;
  logic [7:0] data [4];
  logic valid [4];
  logic rs [4];
  logic busy [4];
  logic ready [4];
  logic done [4];
  int checks = 0;
  int errors = 0;
  logic exp_q [$];
  localparam int CPB [4] = '{16, 16, 16, 4};
  localparam int PE  [4] = '{0, 1, 1, 0};
  localparam int PO  [4] = '{0, 0, 1, 0};
  localparam int SB  [4] = '{1, 1, 1, 2};

  uart_tx_serializer u0 (
    .sample_clk(sample_clk), .rst(rst), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .RsTx(rs[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_serializer #(.PARITY_EN(1)) u1 (
    .sample_clk(sample_clk), .rst(rst), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .RsTx(rs[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_serializer #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .sample_clk(sample_clk), .rst(rst), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .RsTx(rs[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u3 (
    .sample_clk(sample_clk), .rst(rst), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .RsTx(rs[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic push_frame(input int u, input logic [7:0] d);
    repeat (CPB[u]) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB[u]) exp_q.push_back(d[i]);
    if (PE[u] != 0) repeat (CPB[u]) exp_q.push_back(^d ^ (PO[u] != 0));
    repeat (SB[u] * CPB[u]) exp_q.push_back(1'b1);
  endtask

  task automatic accept(input int u, input logic [7:0] d);
    int n = 0;
    data[u] = d;
    valid[u] = 1'b1;
    while (!ready[u] && n < 400) begin
      @(negedge sample_clk);
      n++;
    end
    checks++;
    if (ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL accept u%0d: tx_ready=%b after %0d cycles, required 1", u, ready[u], n);
    end
    @(posedge sample_clk);
    push_frame(u, d);
  endtask

  task automatic drain(input int u, input bit keep, input logic [7:0] next_d, input int pulse_at);
    logic b;
    logic [3:0] got;
    int c = 0;
    while (exp_q.size() > 0) begin
      @(negedge sample_clk);
      if (c == 0) begin
        valid[u] = keep;
        data[u] = keep ? next_d : ~data[u];
      end
      if (pulse_at >= 0 && c == pulse_at) begin
        valid[u] = 1'b1;
        data[u] = 8'h3C;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) valid[u] = 1'b0;
      b = exp_q.pop_front();
      got = {rs[u], busy[u], ready[u], done[u]};
      checks++;
      if (got !== {b, 3'b100}) begin
        errors++;
        $display("FAIL frame u%0d cycle %0d: {RsTx,busy,ready,done}=%b required %b", u, c, got, {b, 3'b100});
      end
      c++;
    end
    @(negedge sample_clk);
    got = {rs[u], busy[u], ready[u], done[u]};
    checks++;
    if (got !== 4'b1011) begin
      errors++;
      $display("FAIL done u%0d after %0d cycles: {RsTx,busy,ready,done}=%b required 1011", u, c, got);
    end
  endtask

  task automatic idle_check(input int u, input int n);
    logic [3:0] got;
    repeat (n) begin
      @(negedge sample_clk);
      got = {rs[u], busy[u], ready[u], done[u]};
      checks++;
      if (got !== 4'b1010) begin
        errors++;
        $display("FAIL idle u%0d: {RsTx,busy,ready,done}=%b required 1010", u, got);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge sample_clk);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if ({rs[u], busy[u], ready[u], done[u]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset u%0d: {RsTx,busy,ready,done}=%b required 1000", u, {rs[u], busy[u], ready[u], done[u]});
      end
    end
    rst = 1'b0;
    @(negedge sample_clk);
    for (int u = 0; u < 4; u++) begin
      checks++;
      if ({rs[u], busy[u], ready[u], done[u]} !== 4'b1010) begin
        errors++;
        $display("FAIL ready_rise u%0d: {RsTx,busy,ready,done}=%b required 1010", u, {rs[u], busy[u], ready[u], done[u]});
      end
    end
  endtask

  task automatic test_basic;
    accept(0, 8'hA5);
    drain(0, 1'b0, 8'h00, -1);
    idle_check(0, 3);
    accept(0, 8'h3B);
    drain(0, 1'b0, 8'h00, -1);
  endtask

  task automatic test_parity;
    accept(1, 8'hA5);
    drain(1, 1'b0, 8'h00, -1);
    accept(2, 8'hA5);
    drain(2, 1'b0, 8'h00, -1);
    accept(1, 8'h07);
    drain(1, 1'b0, 8'h00, -1);
    accept(2, 8'h07);
    drain(2, 1'b0, 8'h00, -1);
  endtask

  task automatic test_stop2;
    accept(3, 8'hFF);
    drain(3, 1'b0, 8'h00, -1);
    idle_check(3, 2);
  endtask

  task automatic test_back_to_back;
    accept(0, 8'h00);
    drain(0, 1'b1, 8'hFF, -1);
    accept(0, 8'hFF);
    drain(0, 1'b0, 8'h00, -1);
    idle_check(0, 2);
  endtask

  task automatic test_busy;
    accept(0, 8'h81);
    drain(0, 1'b0, 8'h00, 60);
    idle_check(0, 4);
  endtask

  task automatic test_reset_mid;
    logic b;
    logic [3:0] got;
    accept(0, 8'h55);
    for (int c = 0; c < 69; c++) begin
      @(negedge sample_clk);
      if (c == 0) valid[0] = 1'b0;
      b = exp_q.pop_front();
      checks++;
      if ({rs[0], busy[0]} !== {b, 1'b1}) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: {RsTx,busy}=%b%b required %b1", c, rs[0], busy[0], b);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    @(negedge sample_clk);
    got = {rs[0], busy[0], ready[0], done[0]};
    checks++;
    if (got !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset: {RsTx,busy,ready,done}=%b required 1000", got);
    end
    rst = 1'b0;
    idle_check(0, 3);
    accept(0, 8'h55);
    drain(0, 1'b0, 8'h00, -1);
  endtask

  initial begin
    for (int u = 0; u < 4; u++) begin
      valid[u] = 1'b0;
      data[u] = 8'h00;
    end
    test_reset;
    test_basic;
    test_parity;
    test_stop2;
    test_back_to_back;
    test_busy;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Serial transmit engine for the UART link; the outgoing counterpart of the majority-vote receive path. It accepts a parallel byte over a valid/ready handshake and emits an asynchronous serial frame on the line. The frame is a start bit, LSB-first data bits, an optional parity bit and stop bits. Every bit is held for a fixed number of `sample_clk` cycles, so bit timing matches the receiver's oversampling clock.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: `sample_clk` cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, 5..8.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.

Ports:
- `sample_clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `tx_data`, in, `DATA_BITS`: byte to send; sampled only on an accepted handshake.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: block can accept a byte this cycle.
- `RsTx`, out, 1: serial line; idles high.
- `tx_busy`, out, 1: a frame is in progress.
- `tx_done`, out, 1: one-cycle pulse when the frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept occurs at an edge where `tx_valid && tx_ready`.
  - The accept latches `tx_data` into the shift register.
  - The state goes to START.
- IDLE: `RsTx` = 1, `tx_ready` = 1, `tx_busy` = 0.
- START: `RsTx` = 0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `RsTx` = shift[0] for each bit; shift right at each bit end.
  - After `DATA_BITS` bits, go to PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: `RsTx` = XOR of the latched data bits, XOR `PARITY_ODD`.
- STOP: `RsTx` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles, then IDLE with `tx_done` = 1 for one cycle.
- All outputs are registered.
- The bit timer counts 0..`CLKS_PER_BIT`-1, and the bit end is at `CLKS_PER_BIT`-1.
  - Counter width is $clog2(`CLKS_PER_BIT`).
  - The bit index width is $clog2(`DATA_BITS`+1).
- `tx_valid` while busy is ignored, with no queuing.
- Changes to `tx_data` after accept do not affect the frame in flight.
- `rst` at any edge, including mid-frame:
  - The frame is aborted with no `tx_done`.
  - The state goes to IDLE and the counters clear.

## Timing
- Reset values: `RsTx` = 1, `tx_ready` = 0, `tx_busy` = 0, `tx_done` = 0.
- `tx_ready` rises at the first edge after `rst` is deasserted.
- Frame length is F = (1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- Cycle positions for an accept at edge k:
  - `RsTx` = 0 and `tx_busy` = 1 after edge k, so start-bit latency is 1 cycle.
  - Data bit i starts after edge k + (1+i) × `CLKS_PER_BIT`.
  - Stop starts after edge k + (1 + `DATA_BITS` + `PARITY_EN`) × `CLKS_PER_BIT`.
  - After edge k+F the state is IDLE, with `tx_done` = 1, `tx_ready` = 1 and `tx_busy` = 0.
- `tx_ready` is 0 from the edge after accept through edge k+F-1.
- The earliest next accept is at edge k+F+1 if `tx_valid` is held.
  - This guarantees exactly one extra idle-high cycle between back-to-back frames.
- `tx_done` and `tx_ready` are both high in the cycle after edge k+F.

## Structure
- Shared package `uart_pkg` holds:
  - the state typedef `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the constant `UART_CLKS_PER_BIT` = 16, shared with the receive path;
  - the constant `UART_LINE_IDLE` = 1'b1.
- One sub-module, `uart_bit_timer`:
  - inputs `sample_clk`, `rst`, `clear`;
  - output `bit_end`, which pulses on the last cycle of each bit period.
- The FSM, shift register and parity accumulator live in the top level.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `DATA_BITS`=8 unless stated.
- Send 0xA5, no parity, 1 stop, accept at edge k:
  - `RsTx` = 0 for 16 cycles, then 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles.
  - `tx_done` pulses after edge k+160.
- Parity, send 0xA5 (four ones):
  - `PARITY_EN`=1, `PARITY_ODD`=0: parity bit is 0 for 16 cycles and `tx_done` is at k+176.
  - `PARITY_ODD`=1: parity bit is 1.
- Back-to-back, `tx_valid` held high with 0x00 then 0xFF:
  - The second start bit begins exactly 2 cycles after the first frame's last stop cycle.
  - `RsTx` is high for exactly 1 cycle between frames.
- Busy protection:
  - Pulse `tx_valid` with 0x3C mid-DATA of a 0x81 frame.
  - The line carries only 0x81, `tx_ready` stays 0, and exactly one `tx_done` pulse occurs.
- Reset mid-frame:
  - Assert `rst` during data bit 3 of 0x55.
  - After that edge: `RsTx` = 1, `tx_busy` = 0, `tx_ready` = 0, and no `tx_done`.
  - After deassert, `tx_ready` = 1 next cycle and a fresh 0x55 frame transmits correctly.
- `STOP_BITS`=2, `CLKS_PER_BIT`=4:
  - Send 0xFF; stop high for 8 cycles.
  - `tx_done` comes at k+44.
